// File: rtl/ex_pkg.sv
// Execute-stage shared definitions.
// ALU codes, multi-cycle FSM states and branch opcode.
package ex_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_XOR  = 4'd3;
  localparam logic [3:0] ALU_NOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SUB  = 4'd6;
  localparam logic [3:0] ALU_SLT  = 4'd7;
  localparam logic [3:0] ALU_SLTU = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_LUI  = 4'd11;
  localparam logic [3:0] ALU_MUL  = 4'd12;
  localparam logic [3:0] ALU_DIVU = 4'd13;
  localparam logic [3:0] ALU_REMU = 4'd14;

  localparam logic [5:0] OPC_BNE = 6'h05;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mdState_t;

  function automatic logic isMd(input logic [3:0] code);
    return (code == ALU_MUL) || (code == ALU_DIVU) ||
           (code == ALU_REMU);
  endfunction

endpackage

// File: rtl/ex_if.sv
// ID/EX inputs, EX/MEM outputs and stall/redirect
// handshake of the execute stage.
interface ex_if;
  import ex_pkg::*;

  logic            valid_in;
  logic            reg_write_in;
  logic            mem_read_in;
  logic            mem_write_in;
  logic            mem_to_reg_in;
  logic            alu_src_in;
  logic            branch_in;
  logic            jump_in;
  logic [4:0]      dest_addr_in;
  logic [3:0]      alu_ctrl_in;
  logic [31:0]     ir_in;
  logic [XLEN-1:0] pc_in;
  logic [XLEN-1:0] a_in;
  logic [XLEN-1:0] b_in;
  logic [XLEN-1:0] branch_target_in;
  logic [XLEN-1:0] jump_target_in;
  logic            hold_in;

  logic            stall_out;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            exmem_valid;
  logic            exmem_reg_write;
  logic            exmem_mem_read;
  logic            exmem_mem_write;
  logic            exmem_mem_to_reg;
  logic [4:0]      exmem_dest_addr;
  logic [XLEN-1:0] exmem_alu_result;
  logic [XLEN-1:0] exmem_store_data;
  logic [XLEN-1:0] exmem_pc;

  modport master (
    output valid_in, reg_write_in, mem_read_in,
    output mem_write_in, mem_to_reg_in, alu_src_in,
    output branch_in, jump_in, dest_addr_in,
    output alu_ctrl_in, ir_in, pc_in, a_in, b_in,
    output branch_target_in, jump_target_in, hold_in,
    input  stall_out, redirect_valid, redirect_pc,
    input  exmem_valid, exmem_reg_write,
    input  exmem_mem_read, exmem_mem_write,
    input  exmem_mem_to_reg, exmem_dest_addr,
    input  exmem_alu_result, exmem_store_data,
    input  exmem_pc
  );

  modport slave (
    input  valid_in, reg_write_in, mem_read_in,
    input  mem_write_in, mem_to_reg_in, alu_src_in,
    input  branch_in, jump_in, dest_addr_in,
    input  alu_ctrl_in, ir_in, pc_in, a_in, b_in,
    input  branch_target_in, jump_target_in, hold_in,
    output stall_out, redirect_valid, redirect_pc,
    output exmem_valid, exmem_reg_write,
    output exmem_mem_read, exmem_mem_write,
    output exmem_mem_to_reg, exmem_dest_addr,
    output exmem_alu_result, exmem_store_data,
    output exmem_pc
  );

endinterface

// File: rtl/ex_muldiv.sv
// Iterative shift-add multiplier / restoring divider,
// one step per cycle, result held in DONE until acked.
module ex_muldiv
  import ex_pkg::*;
#(
  parameter int MD_CYCLES = XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            ack,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(MD_CYCLES);

  mdState_t        state;
  logic [CW-1:0]   cnt;
  logic [3:0]      opr;
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] x;
  logic [XLEN-1:0] y;

  // x shifts dividend bits out and quotient bits in; acc is the remainder
  logic [XLEN:0]   divTrial;
  logic [XLEN:0]   divSub;
  logic            divGe;
  logic [XLEN-1:0] divRem;

  assign divTrial = {acc, x[XLEN-1]};
  assign divSub   = divTrial - {1'b0, y};
  assign divGe    = divTrial >= {1'b0, y};
  assign divRem   = divGe ? divSub[XLEN-1:0]
                          : divTrial[XLEN-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      opr   <= ALU_AND;
      acc   <= '0;
      x     <= '0;
      y     <= '0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          x     <= a;
          y     <= b;
          acc   <= '0;
          cnt   <= '0;
          opr   <= op;
          state <= BUSY;
        end
        BUSY: begin
          if (opr == ALU_MUL) begin
            if (y[0]) acc <= acc + x;
            x <= x << 1;
            y <= y >> 1;
          end else begin
            acc <= divRem;
            x   <= {x[XLEN-2:0], divGe};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CW'(MD_CYCLES - 1)) state <= DONE;
        end
        DONE: if (ack) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy   = ((state == IDLE) && start) || (state == BUSY);
  assign done   = (state == DONE);
  assign result = (opr == ALU_DIVU) ? x : acc;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, branch resolution, multi-cycle
// mul/div hookup and the EX/MEM pipeline register.
module ex_stage
  import ex_pkg::*;
#(
  parameter int MD_CYCLES = XLEN
) (
  input logic clk,
  input logic rst,
  ex_if.slave bus
);

  logic [XLEN-1:0] immExt;
  logic [XLEN-1:0] opB;
  logic [4:0]      shamt;
  logic [XLEN-1:0] aluRes;
  logic [XLEN-1:0] mdRes;
  logic            mdStart;
  logic            mdBusy;
  logic            mdDone;
  logic            taken;
  logic            unusedIr;

  assign unusedIr = ^bus.ir_in[25:16];
  assign immExt   = {{16{bus.ir_in[15]}}, bus.ir_in[15:0]};
  assign opB      = bus.alu_src_in ? immExt : bus.b_in;
  assign shamt    = bus.ir_in[10:6];

  always_comb begin
    aluRes = '0;
    case (bus.alu_ctrl_in)
      ALU_AND:  aluRes = bus.a_in & opB;
      ALU_OR:   aluRes = bus.a_in | opB;
      ALU_ADD:  aluRes = bus.a_in + opB;
      ALU_XOR:  aluRes = bus.a_in ^ opB;
      ALU_NOR:  aluRes = ~(bus.a_in | opB);
      ALU_SLL:  aluRes = opB << shamt;
      ALU_SUB:  aluRes = bus.a_in - opB;
      ALU_SLT:  aluRes = {31'b0, $signed(bus.a_in) < $signed(opB)};
      ALU_SLTU: aluRes = {31'b0, bus.a_in < opB};
      ALU_SRL:  aluRes = opB >> shamt;
      ALU_SRA:  aluRes = $signed(opB) >>> shamt;
      ALU_LUI:  aluRes = {bus.ir_in[15:0], 16'b0};
      default:  aluRes = '0;
    endcase
  end

  assign mdStart = bus.valid_in && isMd(bus.alu_ctrl_in);

  ex_muldiv #(.MD_CYCLES(MD_CYCLES)) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (mdStart),
    .ack    (!bus.hold_in),
    .op     (bus.alu_ctrl_in),
    .a      (bus.a_in),
    .b      (opB),
    .busy   (mdBusy),
    .done   (mdDone),
    .result (mdRes)
  );

  // compare uses raw operands, never the immediate mux
  assign taken = bus.branch_in &&
    ((bus.ir_in[31:26] == OPC_BNE) ? (bus.a_in != bus.b_in)
                                   : (bus.a_in == bus.b_in));

  assign bus.stall_out = !rst && (mdBusy || bus.hold_in);
  assign bus.redirect_valid = !rst && bus.valid_in &&
    !bus.stall_out && (bus.jump_in || taken);
  assign bus.redirect_pc = bus.jump_in ? bus.jump_target_in
                                       : bus.branch_target_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.exmem_valid      <= 1'b0;
      bus.exmem_reg_write  <= 1'b0;
      bus.exmem_mem_read   <= 1'b0;
      bus.exmem_mem_write  <= 1'b0;
      bus.exmem_mem_to_reg <= 1'b0;
      bus.exmem_dest_addr  <= '0;
      bus.exmem_alu_result <= '0;
      bus.exmem_store_data <= '0;
      bus.exmem_pc         <= '0;
    end else if (!bus.hold_in) begin
      if (mdBusy || !bus.valid_in) begin
        bus.exmem_valid     <= 1'b0;
        bus.exmem_reg_write <= 1'b0;
        bus.exmem_mem_read  <= 1'b0;
        bus.exmem_mem_write <= 1'b0;
      end else begin
        bus.exmem_valid      <= 1'b1;
        bus.exmem_reg_write  <= bus.reg_write_in;
        bus.exmem_mem_read   <= bus.mem_read_in;
        bus.exmem_mem_write  <= bus.mem_write_in;
        bus.exmem_mem_to_reg <= bus.mem_to_reg_in;
        bus.exmem_dest_addr  <= bus.dest_addr_in;
        bus.exmem_alu_result <= mdDone ? mdRes : aluRes;
        bus.exmem_store_data <= bus.b_in;
        bus.exmem_pc         <= bus.pc_in;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage.
// Inputs change on negedge; outputs sampled 1ns later.
module tb_ex_stage;
  import ex_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   passed = 0;
  int   nStall;

  ex_if bus ();

  ex_stage u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic clear();
    bus.valid_in         = 1'b0;
    bus.reg_write_in     = 1'b0;
    bus.mem_read_in      = 1'b0;
    bus.mem_write_in     = 1'b0;
    bus.mem_to_reg_in    = 1'b0;
    bus.alu_src_in       = 1'b0;
    bus.branch_in        = 1'b0;
    bus.jump_in          = 1'b0;
    bus.dest_addr_in     = 5'd0;
    bus.alu_ctrl_in      = ALU_AND;
    bus.ir_in            = 32'h0;
    bus.pc_in            = 32'h0;
    bus.a_in             = 32'h0;
    bus.b_in             = 32'h0;
    bus.branch_target_in = 32'h0;
    bus.jump_target_in   = 32'h0;
    bus.hold_in          = 1'b0;
  endtask

  task automatic drive(input logic [3:0] alu, input logic [31:0] a,
                       input logic [31:0] b, input logic src,
                       input logic [31:0] ir);
    @(negedge clk);
    clear();
    bus.valid_in     = 1'b1;
    bus.reg_write_in = 1'b1;
    bus.dest_addr_in = 5'd9;
    bus.pc_in        = 32'h0000_1000;
    bus.alu_ctrl_in  = alu;
    bus.a_in         = a;
    bus.b_in         = b;
    bus.alu_src_in   = src;
    bus.ir_in        = ir;
    #1;
  endtask

  task automatic edgeSample();
    @(posedge clk);
    #1;
  endtask

  task automatic runMd(input string tag, input logic [3:0] alu,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
    drive(alu, a, b, 1'b0, 32'h0);
    nStall = 0;
    while (bus.stall_out === 1'b1 && nStall < 100) begin
      nStall++;
      @(negedge clk);
      #1;
    end
    chk({tag, "_stall"}, nStall, 33);
    chk({tag, "_bubble"}, {31'b0, bus.exmem_valid}, 0);
    edgeSample();
    chk({tag, "_res"}, bus.exmem_alu_result, exp);
    chk({tag, "_vld"}, {31'b0, bus.exmem_valid}, 1);
  endtask

  initial begin
    clear();
    bus.valid_in = 1'b1;
    bus.jump_in  = 1'b1;
    bus.hold_in  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", {31'b0, bus.stall_out}, 0);
    chk("rst_redir", {31'b0, bus.redirect_valid}, 0);
    chk("rst_vld", {31'b0, bus.exmem_valid}, 0);
    chk("rst_res", bus.exmem_alu_result, 0);
    @(negedge clk);
    clear();
    rst = 1'b0;

    drive(ALU_ADD, 32'd5, 32'd7, 1'b0, 32'h0);
    chk("add_stall", {31'b0, bus.stall_out}, 0);
    edgeSample();
    chk("add_res", bus.exmem_alu_result, 32'd12);
    chk("add_vld", {31'b0, bus.exmem_valid}, 1);
    chk("add_dst", {27'b0, bus.exmem_dest_addr}, 9);
    chk("add_sd", bus.exmem_store_data, 32'd7);

    drive(ALU_SUB, 32'd3, 32'd5, 1'b0, 32'h0);
    edgeSample();
    chk("sub_res", bus.exmem_alu_result, 32'hFFFF_FFFE);

    drive(ALU_ADD, 32'd10, 32'd99, 1'b1, 32'h0000_FFFF);
    edgeSample();
    chk("addi_res", bus.exmem_alu_result, 32'd9);
    chk("addi_sd", bus.exmem_store_data, 32'd99);

    drive(ALU_LUI, 32'd0, 32'd0, 1'b1, 32'h0000_1234);
    edgeSample();
    chk("lui_res", bus.exmem_alu_result, 32'h1234_0000);

    drive(ALU_SLTU, 32'd1, 32'hFFFF_FFFF, 1'b0, 32'h0);
    edgeSample();
    chk("sltu_res", bus.exmem_alu_result, 32'd1);

    drive(ALU_SLT, 32'd1, 32'hFFFF_FFFF, 1'b0, 32'h0);
    edgeSample();
    chk("slt_res", bus.exmem_alu_result, 32'd0);

    drive(ALU_SUB, 32'd8, 32'd8, 1'b0, 32'h1000_0000);
    bus.branch_in = 1'b1;
    bus.branch_target_in = 32'h40;
    #1;
    chk("beq_redir", {31'b0, bus.redirect_valid}, 1);
    chk("beq_pc", bus.redirect_pc, 32'h40);
    edgeSample();
    chk("beq_vld", {31'b0, bus.exmem_valid}, 1);

    drive(ALU_SUB, 32'd8, 32'd8, 1'b0, 32'h1400_0000);
    bus.branch_in = 1'b1;
    bus.branch_target_in = 32'h40;
    #1;
    chk("bne_redir", {31'b0, bus.redirect_valid}, 0);

    bus.jump_in = 1'b1;
    bus.jump_target_in = 32'h100;
    #1;
    chk("jmp_redir", {31'b0, bus.redirect_valid}, 1);
    chk("jmp_pc", bus.redirect_pc, 32'h100);
    bus.valid_in = 1'b0;
    #1;
    chk("inv_redir", {31'b0, bus.redirect_valid}, 0);
    edgeSample();
    chk("inv_bubble", {31'b0, bus.exmem_valid}, 0);

    drive(ALU_ADD, 32'd1, 32'd1, 1'b0, 32'h0);
    edgeSample();
    runMd("mul", ALU_MUL, 32'd7, 32'd6, 32'd42);
    runMd("divu", ALU_DIVU, 32'd100, 32'd7, 32'd14);
    runMd("remu", ALU_REMU, 32'd100, 32'd7, 32'd2);
    runMd("divz", ALU_DIVU, 32'd9, 32'd0, 32'hFFFF_FFFF);
    runMd("remz", ALU_REMU, 32'd9, 32'd0, 32'd9);

    drive(ALU_MUL, 32'd3, 32'd3, 1'b0, 32'h0);
    repeat (11) @(posedge clk);
    @(negedge clk);
    #1;
    chk("busy_stall", {31'b0, bus.stall_out}, 1);
    rst = 1'b1;
    #1;
    chk("mrst_stall", {31'b0, bus.stall_out}, 0);
    chk("mrst_vld", {31'b0, bus.exmem_valid}, 0);
    chk("mrst_res", bus.exmem_alu_result, 0);
    clear();
    @(negedge clk);
    rst = 1'b0;
    edgeSample();
    chk("post_stall", {31'b0, bus.stall_out}, 0);

    drive(ALU_ADD, 32'd20, 32'd22, 1'b0, 32'h0);
    edgeSample();
    chk("pre_hold", bus.exmem_alu_result, 32'd42);
    drive(ALU_ADD, 32'd1, 32'd2, 1'b0, 32'h0);
    bus.hold_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_stall", {31'b0, bus.stall_out}, 1);
      edgeSample();
      chk("hold_res", bus.exmem_alu_result, 32'd42);
    end
    @(negedge clk);
    bus.hold_in = 1'b0;
    #1;
    chk("unhold_stall", {31'b0, bus.stall_out}, 0);
    edgeSample();
    chk("unhold_res", bus.exmem_alu_result, 32'd3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
